// File: rtl/analog_pad_sequencer.sv
// Wishbone-controlled break-before-make sequencer for pads shared with analog macros.
// Changed pads go hi-Z, wait a guard delay, take new values, then settle before DONE.
module analog_pad_sequencer #(
    parameter int          NPADS          = 6,
    parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
    parameter int          GUARD_CYCLES   = 4,
    parameter logic [15:0] SETTLE_DEFAULT = 16'd256
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [NPADS-1:0] pad_oeb_o,
    output logic [NPADS-1:0] pad_out_o,
    output logic             irq_o
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GLAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BREAK  = 2'd1,
        S_MAKE   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NPADS-1:0] tgt_oeb, tgt_out, snap_oeb, snap_out, chg;
    logic [15:0]      settle, snap_settle, scnt;
    logic [GW-1:0]    gcnt;
    logic             irq_en, done, err;
    logic             busy, done_set, enter_make;

    logic        hit, acc, wr, rd, go, go_ok, go_err, w1c;
    logic        off_oeb, off_out, off_ctrl, off_stat, off_set;
    logic [31:0] bmask, rdata;
    logic        unused_ok;

    assign hit = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
    assign acc = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;
    assign wr  = acc & wbs_we_i;
    assign rd  = acc & ~wbs_we_i;

    assign off_oeb  = (wbs_adr_i[4:2] == 3'd0);
    assign off_out  = (wbs_adr_i[4:2] == 3'd1);
    assign off_ctrl = (wbs_adr_i[4:2] == 3'd2);
    assign off_stat = (wbs_adr_i[4:2] == 3'd3);
    assign off_set  = (wbs_adr_i[4:2] == 3'd4);

    assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign go     = wr & off_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
    assign go_ok  = go & ~busy;
    assign go_err = go & busy;
    assign w1c    = wr & off_stat & wbs_sel_i[0];
    assign chg    = (tgt_oeb ^ pad_oeb_o) | (tgt_out ^ pad_out_o);

    assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i, bmask};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (go) state_nxt = S_BREAK;
            S_BREAK:  if (gcnt == GLAST) state_nxt = S_MAKE;
            S_MAKE:   state_nxt = (snap_settle == 16'd0) ? S_IDLE : S_SETTLE;
            S_SETTLE: if (scnt == 16'd1) state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done_set   = busy && (state_nxt == S_IDLE);
        enter_make = (state == S_BREAK) && (state_nxt == S_MAKE);
        irq_o      = done & irq_en;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            off_oeb:  rdata = 32'(tgt_oeb);
            off_out:  rdata = 32'(tgt_out);
            off_ctrl: rdata = {30'd0, irq_en, 1'b0};
            off_stat: rdata = {27'd0, state, err, done, busy};
            off_set:  rdata = {16'd0, settle};
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            pad_oeb_o   <= '1;
            pad_out_o   <= '0;
            tgt_oeb     <= '1;
            tgt_out     <= '0;
            snap_oeb    <= '1;
            snap_out    <= '0;
            settle      <= SETTLE_DEFAULT;
            snap_settle <= SETTLE_DEFAULT;
            scnt        <= '0;
            gcnt        <= '0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= rd ? rdata : '0;
            if (wr && off_oeb)
                tgt_oeb <= (tgt_oeb & ~bmask[NPADS-1:0])
                         | (wbs_dat_i[NPADS-1:0] & bmask[NPADS-1:0]);
            if (wr && off_out)
                tgt_out <= (tgt_out & ~bmask[NPADS-1:0])
                         | (wbs_dat_i[NPADS-1:0] & bmask[NPADS-1:0]);
            if (wr && off_set)
                settle <= (settle & ~bmask[15:0]) | (wbs_dat_i[15:0] & bmask[15:0]);
            if (wr && off_ctrl && wbs_sel_i[0])
                irq_en <= wbs_dat_i[1];
            // a completing sequence beats a same-cycle W1C of DONE
            if (done_set)                 done <= 1'b1;
            else if (go_ok)               done <= 1'b0;
            else if (w1c && wbs_dat_i[1]) done <= 1'b0;
            if (go_err)                   err <= 1'b1;
            else if (w1c && wbs_dat_i[2]) err <= 1'b0;
            if (go_ok) begin
                snap_oeb    <= tgt_oeb;
                snap_out    <= tgt_out;
                snap_settle <= settle;
                pad_oeb_o   <= pad_oeb_o | chg;
                gcnt        <= '0;
            end
            if (state == S_BREAK) gcnt <= gcnt + 1'b1;
            if (enter_make) pad_out_o <= snap_out;
            if (state == S_MAKE) begin
                pad_oeb_o <= snap_oeb;
                scnt      <= snap_settle;
            end
            if (state == S_SETTLE) scnt <= scnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_analog_pad_sequencer.sv
// Directed bench for analog_pad_sequencer: register access, sequence
// timing, break-before-make, error/W1C handling and mid-sequence reset.
module tb_analog_pad_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [5:0]  oeb, out;
    logic        irq;
    logic [31:0] r;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] B = 32'h3000_0000;

    always #5 clk = ~clk;

    analog_pad_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .pad_oeb_o(oeb),
        .pad_out_o(out),
        .irq_o    (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] q);
        @(posedge clk); #1;
        chk("ack_pre", 32'(ack), 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        chk("ack", 32'(ack), 32'd1);
        q = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb(1'b1, a, d, 4'hF, q);
    endtask

    // Called right after the GO access; walks the whole sequence cycle by cycle.
    task automatic run_seq(input string tag, input logic [5:0] o_oeb, input logic [5:0] o_out,
                           input logic [5:0] n_oeb, input logic [5:0] n_out, input int st);
        logic [5:0] c, e_oeb, e_out;
        c = (o_oeb ^ n_oeb) | (o_out ^ n_out);
        for (int k = 0; k <= 5 + st; k++) begin
            e_oeb = (k < 5) ? (o_oeb | c) : n_oeb;
            e_out = (k < 4) ? o_out : n_out;
            chk({tag, "_oeb"}, 32'(oeb), 32'(e_oeb));
            chk({tag, "_out"}, 32'(out), 32'(e_out));
            chk({tag, "_irq"}, 32'(irq), 32'(k >= 5 + st));
            if (k < 5 + st) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; wdat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oeb", 32'(oeb), 32'h3F);
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        rst = 1'b0;

        wb(1'b0, B + 32'h10, 32'd0, 4'hF, r);
        chk("settle_rst", r, 32'h100);
        @(posedge clk); #1;
        chk("ack_one", 32'(ack), 32'd0);

        // miss-decoded address: never acked
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = B + 32'h40; wdat = 32'hFF; sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("miss_ack", 32'(ack), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb(1'b0, B + 32'h00, 32'd0, 4'hF, r);
        chk("miss_nowr", r, 32'h3F);
        wb(1'b1, B + 32'h14, 32'hFFFF, 4'hF, r);
        wb(1'b0, B + 32'h14, 32'd0, 4'hF, r);
        chk("unmapped", r, 32'd0);

        // first sequence
        wr32(B + 32'h00, 32'h3C);
        wr32(B + 32'h04, 32'h01);
        wr32(B + 32'h10, 32'd3);
        wb(1'b0, B + 32'h08, 32'd0, 4'hF, r);
        chk("ctrl_rd0", r, 32'd0);
        wr32(B + 32'h08, 32'h3);
        run_seq("seq1", 6'h3F, 6'h00, 6'h3C, 6'h01, 3);
        wb(1'b0, B + 32'h0C, 32'd0, 4'hF, r);
        chk("stat_done", r, 32'h2);
        wb(1'b0, B + 32'h08, 32'd0, 4'hF, r);
        chk("ctrl_go_rd0", r, 32'h2);

        // break-before-make on bit1
        wr32(B + 32'h00, 32'h3E);
        wr32(B + 32'h04, 32'h02);
        wr32(B + 32'h08, 32'h3);
        run_seq("bbm", 6'h3C, 6'h01, 6'h3E, 6'h02, 3);

        // GO while in SETTLE, with no changed pads
        wr32(B + 32'h08, 32'h3);
        repeat (4) @(posedge clk);
        wr32(B + 32'h08, 32'h3);
        chk("err_irq6", 32'(irq), 32'd0);
        chk("err_oeb", 32'(oeb), 32'h3E);
        chk("err_out", 32'(out), 32'h02);
        @(posedge clk); #1;
        chk("err_irq7", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("err_irq8", 32'(irq), 32'd1);
        wb(1'b0, B + 32'h0C, 32'd0, 4'hF, r);
        chk("stat_err", r, 32'h6);
        wr32(B + 32'h0C, 32'h4);
        wb(1'b0, B + 32'h0C, 32'd0, 4'hF, r);
        chk("w1c_err", r, 32'h2);
        chk("w1c_err_irq", 32'(irq), 32'd1);

        // W1C DONE drops irq
        wr32(B + 32'h0C, 32'h2);
        chk("w1c_done_irq", 32'(irq), 32'd0);
        wb(1'b0, B + 32'h0C, 32'd0, 4'hF, r);
        chk("stat_clr", r, 32'h0);

        // byte-select write to SETTLE
        wr32(B + 32'h10, 32'h0100);
        wb(1'b1, B + 32'h10, 32'h0000_FF05, 4'b0001, r);
        wb(1'b0, B + 32'h10, 32'd0, 4'hF, r);
        chk("settle_sel", r, 32'h0105);

        // SETTLE=0 goes straight to IDLE after MAKE
        wr32(B + 32'h10, 32'd0);
        wr32(B + 32'h00, 32'h3F);
        wr32(B + 32'h04, 32'h00);
        wr32(B + 32'h08, 32'h3);
        run_seq("st0", 6'h3E, 6'h02, 6'h3F, 6'h00, 0);

        // reset in the middle of BREAK
        wr32(B + 32'h10, 32'd3);
        wr32(B + 32'h00, 32'h00);
        wr32(B + 32'h04, 32'h15);
        wr32(B + 32'h08, 32'h3);
        chk("mid_brk_oeb", 32'(oeb), 32'h3F);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_oeb", 32'(oeb), 32'h3F);
        chk("mrst_out", 32'(out), 32'h00);
        chk("mrst_irq", 32'(irq), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("mrst_hold_oeb", 32'(oeb), 32'h3F);
        chk("mrst_hold_out", 32'(out), 32'h00);
        wb(1'b0, B + 32'h00, 32'd0, 4'hF, r);
        chk("mrst_tgt", r, 32'h3F);
        wb(1'b0, B + 32'h0C, 32'd0, 4'hF, r);
        chk("mrst_stat", r, 32'h0);
        wb(1'b0, B + 32'h08, 32'd0, 4'hF, r);
        chk("mrst_ctrl", r, 32'h0);
        wb(1'b0, B + 32'h10, 32'd0, 4'hF, r);
        chk("mrst_settle", r, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
